hazard_unit_mc: RTL
===================

// Module: hazard_unit_mc
// PURPOSE
//   Parametrised hazard unit for the 5-stage RV32I pipeline with a variable-latency data memory.
//   - Forwarding selects for the Execute-stage ALU operands.
//   - Multi-cycle load-use stall handling, sequenced by a small FSM.
//   - Memory-wait freeze of the F/D/E/M stages.
//   - Branch/jump flush.
//   Sits beside the datapath; all outputs drive the pipeline-register enables and clears.
// PARAMETERS
//   REG_ADDR_W       5   register-index width
//   LOAD_USE_STALLS  1   bubbles inserted per load-use hazard (>=1; 2 for a 2-cycle load path)
//   CNT_W            32  width of the performance counters (used only with HAZ_PERF_CNT_EN)
// PORTS
//   clk         in   1             pipeline clock, rising edge
//   rst         in   1             asynchronous, active-high reset
//   Rs1D, Rs2D  in   REG_ADDR_W    source registers in Decode
//   Rs1E, Rs2E  in   REG_ADDR_W    source registers in Execute
//   RdE         in   REG_ADDR_W    destination register in Execute
//   RdM         in   REG_ADDR_W    destination register in Memory
//   RdW         in   REG_ADDR_W    destination register in Writeback
//   RegWriteM   in   1             Memory-stage instruction writes the register file
//   RegWriteW   in   1             Writeback-stage instruction writes the register file
//   ResultSrcE  in   2             2'b01 = Execute-stage instruction is a load
//   PCSrcE      in   1             taken branch/jump resolved in Execute
//   MemReqM     in   1             Memory stage has an active data-memory access
//   MemReadyM   in   1             data memory completes the access this cycle
//   ForwardAE   out  2             ALU A select: 00 = RF, 01 = W result, 10 = M ALU result
//   ForwardBE   out  2             ALU B select, same encoding
//   StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
//   FlushD, FlushE, FlushW          out  1  clear the corresponding pipeline register to a bubble
// BEHAVIOUR
//   Forwarding (combinational):
//     - ForwardAE = 10 if RegWriteM && RdM == Rs1E && RdM != 0;
//       else 01 if RegWriteW && RdW == Rs1E && RdW != 0; else 00.
//     - ForwardBE: same rules using Rs2E. M has priority over W.
//   Memory wait (combinational): memwait = MemReqM & ~MemReadyM.
//     - StallF = StallD = StallE = StallM = 1, FlushW = 1.
//     - All other flushes 0; FSM state and counter hold.
//     - Highest priority over everything below.
//   Load-use detect: lu_hit = (ResultSrcE == 2'b01) & (RdE != 0) & (Rs1D == RdE | Rs2D == RdE).
//   FSM state RUN:
//     - lu_hit: StallF = StallD = 1, FlushE = 1.
//       - LOAD_USE_STALLS > 1: go to LU_WAIT, cnt <= LOAD_USE_STALLS-1.
//       - LOAD_USE_STALLS == 1: stay in RUN.
//     - PCSrcE: FlushD = FlushE = 1, no stalls. Branch wins if asserted together with lu_hit.
//   FSM state LU_WAIT:
//     - StallF = StallD = 1, FlushE = 1 every cycle (E holds bubbles, lu_hit ignored).
//     - cnt decrements each non-memwait cycle; at cnt == 1 the next state is RUN.
//   Outputs not asserted by an active rule are 0; StallE, StallM and FlushW are asserted only by memwait.
//   Latency:
//     - Forward/stall/flush outputs are combinational in the same cycle.
//     - FSM updates on clk rising edge.
//     - Exactly LOAD_USE_STALLS bubbles per load-use hazard, excluding memwait cycles.
//   Reset (async, any time incl. mid-LU_WAIT):
//     - State RUN, cnt 0, perf counters 0.
//     - While rst is high, every stall/flush output is 0 and ForwardAE/BE are 00.
// CONFIGURATION
//   HAZ_PERF_CNT_EN defined:
//     - Adds outputs StallCnt and FlushCnt (out, CNT_W), saturating at all-ones.
//     - StallCnt increments on every clk edge with StallF == 1.
//     - FlushCnt increments on every edge with PCSrcE & ~memwait.
//   HAZ_PERF_CNT_EN undefined: ports and counter logic absent; all other behaviour identical.
// TESTING
//   1 RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10;
//     RdM = 0, Rs1E = 0 -> 00.
//   2 LOAD_USE_STALLS = 2, load RdE = 7, Rs2D = 7 -> StallF/StallD/FlushE = 1 for exactly 2 cycles, then 0.
//   3 MemReqM = 1, MemReadyM = 0 for 3 cycles during LU_WAIT -> StallF..StallM and FlushW = 1 those cycles;
//     LU bubble count still 2.
//   4 PCSrcE = 1 with lu_hit = 1 -> FlushD = FlushE = 1, StallF = 0, state stays RUN.
//   5 rst pulsed mid-LU_WAIT -> all outputs 0 immediately; next lu_hit restarts full bubble count.
//   6 HAZ_PERF_CNT_EN, CNT_W = 4, 20 stall cycles -> StallCnt saturates at 4'hF.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// ----------------------------------------------------------------------------
// hazard_unit_mc_if
// Bundle of every signal exchanged between the pipeline datapath and the
// hazard unit.
//   master : datapath side; drives register indices and stage status and
//            receives the forward selects, stalls and flushes.
//   slave  : hazard-unit side (the mirror image of master).
// Parameters:
//   REG_ADDR_W : register-index width
//   CNT_W      : width of the performance counters (HAZ_PERF_CNT_EN only)
// Optional feature macro: HAZ_PERF_CNT_EN adds StallCnt / FlushCnt.
// ----------------------------------------------------------------------------
interface hazard_unit_mc_if #(
    parameter int REG_ADDR_W = 5
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic                  RegWriteM, RegWriteW;
    logic [1:0]            ResultSrcE;
    logic                  PCSrcE;
    logic                  MemReqM, MemReadyM;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  StallF, StallD, StallE, StallM;
    logic                  FlushD, FlushE, FlushW;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]      StallCnt, FlushCnt;
`endif

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW
`ifdef HAZ_PERF_CNT_EN
        , input StallCnt, FlushCnt
`endif
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW
`ifdef HAZ_PERF_CNT_EN
        , output StallCnt, FlushCnt
`endif
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// ----------------------------------------------------------------------------
// hazard_unit_mc
// Hazard unit for a 5-stage RV32I pipeline with a variable-latency data
// memory: EX operand forwarding, multi-cycle load-use stalls, memory-wait
// freeze of F/D/E/M and branch/jump flush.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-high reset
//   hif  : hazard_unit_mc_if.slave (stage indices/status in; forward selects,
//          stalls and flushes out; optional perf counters out)
// Parameters:
//   REG_ADDR_W      : register-index width
//   LOAD_USE_STALLS : bubbles inserted per load-use hazard (>= 1)
//   CNT_W           : perf counter width (HAZ_PERF_CNT_EN only)
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating StallCnt/FlushCnt.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_RUN     | normal flow; detects load-use hazards and branch flushes
// S_LU_WAIT | inserting the remaining load-use bubbles (F/D held, E bubble)
// ----------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    hazard_unit_mc_if.slave    hif
);

    localparam int LU_CNT_W = (LOAD_USE_STALLS > 1) ? $clog2(LOAD_USE_STALLS) : 1;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {S_RUN, S_LU_WAIT} state_t;

    state_t              r_state;
    logic [LU_CNT_W-1:0] r_cnt;

    logic       w_memwait, w_lu_hit;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic       w_flush_d, w_flush_e, w_flush_w;

    assign w_memwait = hif.MemReqM & ~hif.MemReadyM;
    assign w_lu_hit  = (hif.ResultSrcE == 2'b01) && (hif.RdE != ZERO_REG) &&
                       ((hif.Rs1D == hif.RdE) || (hif.Rs2D == hif.RdE));

    // Memory-stage result has priority over writeback (it is younger).
    always_comb begin
        w_fwd_a = 2'b00;
        if (hif.RegWriteM && hif.RdM == hif.Rs1E && hif.RdM != ZERO_REG)
            w_fwd_a = 2'b10;
        else if (hif.RegWriteW && hif.RdW == hif.Rs1E && hif.RdW != ZERO_REG)
            w_fwd_a = 2'b01;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (hif.RegWriteM && hif.RdM == hif.Rs2E && hif.RdM != ZERO_REG)
            w_fwd_b = 2'b10;
        else if (hif.RegWriteW && hif.RdW == hif.Rs2E && hif.RdW != ZERO_REG)
            w_fwd_b = 2'b01;
    end

    // Memory wait freezes everything up to M and drops the W slot; it also
    // suppresses the E bubble so an in-flight load-use sequence resumes intact.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (w_memwait) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (r_state == S_LU_WAIT) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (hif.PCSrcE) begin
            // Taken branch squashes the dependent instruction anyway.
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lu_hit) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (!w_memwait) begin
            case (r_state)
                S_RUN: begin
                    if (!hif.PCSrcE && w_lu_hit && (LOAD_USE_STALLS > 1)) begin
                        r_state <= S_LU_WAIT;
                        r_cnt   <= LU_CNT_W'(LOAD_USE_STALLS - 1);
                    end
                end
                S_LU_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == LU_CNT_W'(1))
                        r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are forced quiet for the whole time reset is asserted.
    assign hif.ForwardAE = rst ? 2'b00 : w_fwd_a;
    assign hif.ForwardBE = rst ? 2'b00 : w_fwd_b;
    assign hif.StallF    = w_stall_f & ~rst;
    assign hif.StallD    = w_stall_d & ~rst;
    assign hif.StallE    = w_stall_e & ~rst;
    assign hif.StallM    = w_stall_m & ~rst;
    assign hif.FlushD    = w_flush_d & ~rst;
    assign hif.FlushE    = w_flush_e & ~rst;
    assign hif.FlushW    = w_flush_w & ~rst;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (hif.PCSrcE && !w_memwait && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hif.StallCnt = r_stall_cnt;
    assign hif.FlushCnt = r_flush_cnt;
`endif

endmodule
